// File: rtl/pipo_reg_if.sv
// rtl/pipo_reg_if.sv - parallel data bus for the 4-bit PIPO register (optional q_par under PIPO_PARITY_EN)
interface pipo_reg_if;
  // Parallel data into the register, bit 3 is the MSB
  logic p3;
  logic p2;
  logic p1;
  logic p0;
  // Registered data out of the register, bit 3 is the MSB
  logic q0;
  logic q1;
  logic q2;
  logic q3;
`ifdef PIPO_PARITY_EN
  // Registered even-parity bit of the captured word
  logic q_par;
`endif

`ifdef PIPO_PARITY_EN
  // Driver side: presents p*, observes q* and q_par
  modport master (
    output p3, p2, p1, p0,
    input  q0, q1, q2, q3, q_par
  );

  // Register side: consumes p*, drives q* and q_par
  modport slave (
    input  p3, p2, p1, p0,
    output q0, q1, q2, q3, q_par
  );
`else
  // Driver side: presents p*, observes q*
  modport master (
    output p3, p2, p1, p0,
    input  q0, q1, q2, q3
  );

  // Register side: consumes p*, drives q*
  modport slave (
    input  p3, p2, p1, p0,
    output q0, q1, q2, q3
  );
`endif
endinterface

// File: rtl/pipo_reg.sv
// rtl/pipo_reg.sv - 4-bit parallel-in/parallel-out register, async active-low reset, optional PIPO_PARITY_EN parity
module pipo_reg #(
  parameter logic [3:0] RESET_VALUE = 4'b0000
) (
  input  logic          clk,
  input  logic          rst,
  pipo_reg_if.slave     bus
);

  logic [3:0] data_d;
  logic [3:0] data_q;

  // Gather the scalar inputs into a positional word (pN lands in bit N)
  always_comb begin
    data_d = {bus.p3, bus.p2, bus.p1, bus.p0};
  end

  // Load every rising edge; reset wins at once, independent of the clock
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data_q <= RESET_VALUE;
    end else begin
      data_q <= data_d;
    end
  end

  assign bus.q0 = data_q[0];
  assign bus.q1 = data_q[1];
  assign bus.q2 = data_q[2];
  assign bus.q3 = data_q[3];

`ifdef PIPO_PARITY_EN
  logic par_d;
  logic par_q;

  // Parity is taken from the inputs so it tracks the word loaded on the same edge
  always_comb begin
    par_d = ^data_d;
  end

  // Parity register shares the data register's load and reset behaviour
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      par_q <= ^RESET_VALUE;
    end else begin
      par_q <= par_d;
    end
  end

  assign bus.q_par = par_q;
`endif

endmodule

// File: tb/tb_pipo_reg.sv
// tb/tb_pipo_reg.sv - testbench for pipo_reg
module tb_pipo_reg;
  localparam logic [3:0] RV = 4'b0000;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;
  logic [3:0] exp_q;

  pipo_reg_if bus ();

  pipo_reg #(.RESET_VALUE(RV)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    #10;
    forever begin
      clk = 1'b1;
      #5;
      clk = 1'b0;
      #5;
    end
  end

  function automatic logic [3:0] q_word();
    return {bus.q3, bus.q2, bus.q1, bus.q0};
  endfunction

  task automatic drive_p(input logic [3:0] v);
    bus.p3 = v[3];
    bus.p2 = v[2];
    bus.p1 = v[1];
    bus.p0 = v[0];
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive_p(4'b0101);
    @(posedge clk);
    #1;
    n_checks++;
    if (q_word() !== 4'b0101) begin
      n_fail++;
      $display("FAIL pre_reset_capture: got %b expected %b", q_word(), 4'b0101);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_checks++;
    if (q_word() !== RV) begin
      n_fail++;
      $display("FAIL reset_immediate: got %b expected %b", q_word(), RV);
    end
`ifdef PIPO_PARITY_EN
    n_checks++;
    if (bus.q_par !== ^RV) begin
      n_fail++;
      $display("FAIL reset_parity: got %b expected %b", bus.q_par, ^RV);
    end
`endif
    @(posedge clk);
    #1;
    n_checks++;
    if (q_word() !== RV) begin
      n_fail++;
      $display("FAIL reset_held: got %b expected %b", q_word(), RV);
    end
  endtask

  task automatic test_capture();
    @(negedge clk);
    rst = 1'b1;
    drive_p(4'b1100);
    #1;
    n_checks++;
    if (q_word() !== RV) begin
      n_fail++;
      $display("FAIL capture_not_early: got %b expected %b", q_word(), RV);
    end
    @(posedge clk);
    #1;
    n_checks++;
    if (q_word() !== 4'b1100) begin
      n_fail++;
      $display("FAIL capture_1100: got %b expected %b", q_word(), 4'b1100);
    end
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    drive_p(4'b1001);
    @(posedge clk);
    #1;
    n_checks++;
    if (q_word() !== 4'b1001) begin
      n_fail++;
      $display("FAIL b2b_1001: got %b expected %b", q_word(), 4'b1001);
    end
`ifdef PIPO_PARITY_EN
    n_checks++;
    if (bus.q_par !== 1'b0) begin
      n_fail++;
      $display("FAIL parity_1001: got %b expected %b", bus.q_par, 1'b0);
    end
`endif
    @(negedge clk);
    drive_p(4'b1101);
    #1;
    n_checks++;
    if (q_word() !== 4'b1001) begin
      n_fail++;
      $display("FAIL b2b_hold: got %b expected %b", q_word(), 4'b1001);
    end
    @(posedge clk);
    #1;
    n_checks++;
    if (q_word() !== 4'b1101) begin
      n_fail++;
      $display("FAIL b2b_1101: got %b expected %b", q_word(), 4'b1101);
    end
`ifdef PIPO_PARITY_EN
    n_checks++;
    if (bus.q_par !== 1'b1) begin
      n_fail++;
      $display("FAIL parity_1101: got %b expected %b", bus.q_par, 1'b1);
    end
`endif
  endtask

  task automatic test_reset_midcycle();
    @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    n_checks++;
    if (q_word() !== RV) begin
      n_fail++;
      $display("FAIL midcycle_reset: got %b expected %b", q_word(), RV);
    end
    drive_p(4'b1111);
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #1;
      n_checks++;
      if (q_word() !== RV) begin
        n_fail++;
        $display("FAIL midcycle_hold edge %0d: got %b expected %b", i, q_word(), RV);
      end
    end
  endtask

  task automatic test_reset_release();
    @(negedge clk);
    rst = 1'b1;
    #1;
    n_checks++;
    if (q_word() !== RV) begin
      n_fail++;
      $display("FAIL release_hold: got %b expected %b", q_word(), RV);
    end
    @(posedge clk);
    #1;
    n_checks++;
    if (q_word() !== 4'b1111) begin
      n_fail++;
      $display("FAIL release_capture: got %b expected %b", q_word(), 4'b1111);
    end
  endtask

  task automatic test_reset_on_edge();
    @(negedge clk);
    drive_p(4'b1010);
    @(posedge clk);
    rst = 1'b0;
    #1;
    n_checks++;
    if (q_word() !== RV) begin
      n_fail++;
      $display("FAIL reset_on_edge: got %b expected %b", q_word(), RV);
    end
    @(negedge clk);
    rst = 1'b1;
  endtask

  // Reference: the register shows the word presented at the last edge while
  // run, or RESET_VALUE after any reset until the next edge in run.
  task automatic test_random();
    logic [3:0] v;
    exp_q = q_word() === RV ? RV : RV;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      v = 4'($urandom);
      drive_p(v);
      if ($urandom_range(0, 9) == 0) begin
        #1;
        rst = 1'b0;
        exp_q = RV;
        #1;
        n_checks++;
        if (q_word() !== exp_q) begin
          n_fail++;
          $display("FAIL random_reset iter %0d: got %b expected %b", i, q_word(), exp_q);
        end
        #1;
        rst = 1'b1;
        #1;
        n_checks++;
        if (q_word() !== exp_q) begin
          n_fail++;
          $display("FAIL random_release iter %0d: got %b expected %b", i, q_word(), exp_q);
        end
      end
      @(posedge clk);
      exp_q = v;
      #1;
      n_checks++;
      if (q_word() !== exp_q) begin
        n_fail++;
        $display("FAIL random_capture iter %0d: got %b expected %b", i, q_word(), exp_q);
      end
`ifdef PIPO_PARITY_EN
      n_checks++;
      if (bus.q_par !== ^exp_q) begin
        n_fail++;
        $display("FAIL random_parity iter %0d: got %b expected %b", i, bus.q_par, ^exp_q);
      end
`endif
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst      = 1'b1;
    drive_p(4'b0000);
    test_reset();
    test_capture();
    test_back_to_back();
    test_reset_midcycle();
    test_reset_release();
    test_reset_on_edge();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
